// File: rtl/aux_line_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : aux_line_renderer
//  Purpose  : Renders one aux memory word per text row as a horizontal bar of
//             bits. Each line fetches the row's word on the h_sync rising edge,
//             then shifts it out MSB-first, CELL_WIDTH pixels per bit.
//  Ports    : clock_in         - pixel clock, sole clock
//             reset_in         - synchronous reset, active-low
//             v_sync_in        - vertical sync, active-low (frame restart)
//             h_sync_in        - horizontal sync, active-low
//             video_on_in      - high during active pixels of a line
//             aux_data_in      - aux memory read data (cycle after address)
//             aux_raddress_out - aux memory read address (= text row)
//             aux_rd_out       - one-cycle read strobe per fetch
//             pixel_on_out     - registered pixel value
//             late_fetch_out   - sticky: video started before word was loaded
//  Revision : 1.0 - initial release
// ============================================================================
module aux_line_renderer #(
    parameter int DATA_WIDTH        = 16,
    parameter int AUX_ADDRESS_WIDTH = 5,
    parameter int AUX_ELEMENTS      = 32,
    parameter int CELL_WIDTH        = 8,
    parameter int ROW_HEIGHT        = 8
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         v_sync_in,
    input  logic                         h_sync_in,
    input  logic                         video_on_in,
    input  logic [DATA_WIDTH-1:0]        aux_data_in,
    output logic [AUX_ADDRESS_WIDTH-1:0] aux_raddress_out,
    output logic                         aux_rd_out,
    output logic                         pixel_on_out,
    output logic                         late_fetch_out
);

    localparam int c_LINE_MAX  = AUX_ELEMENTS * ROW_HEIGHT;
    localparam int c_LINE_W    = $clog2(c_LINE_MAX + 1);
    localparam int c_ROW_SHIFT = $clog2(ROW_HEIGHT);
    localparam int c_BIT_W     = $clog2(DATA_WIDTH + 1);
    localparam int c_CELL_W    = (CELL_WIDTH > 1) ? $clog2(CELL_WIDTH) : 1;

    localparam logic [c_LINE_W-1:0] c_LINE_SAT  = c_LINE_W'(c_LINE_MAX);
    localparam logic [c_LINE_W-1:0] c_ROWS      = c_LINE_W'(AUX_ELEMENTS);
    localparam logic [c_BIT_W-1:0]  c_BITS      = c_BIT_W'(DATA_WIDTH);
    localparam logic [c_CELL_W-1:0] c_CELL_LAST = c_CELL_W'(CELL_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_LOAD  = 3'd3,
        S_READY = 3'd4,
        S_DRAW  = 3'd5,
        S_BLANK = 3'd6
    } state_t;

    state_t                         r_state_q,   w_state_d;
    logic [c_LINE_W-1:0]            r_line_q,    w_line_d;
    logic [DATA_WIDTH-1:0]          r_buf_q,     w_buf_d;
    logic [c_BIT_W-1:0]             r_bit_q,     w_bit_d;
    logic [c_CELL_W-1:0]            r_cell_q,    w_cell_d;
    logic [AUX_ADDRESS_WIDTH-1:0]   r_addr_q,    w_addr_d;
    logic                           r_rd_q,      w_rd_d;
    logic                           r_pix_q,     w_pix_d;
    logic                           r_late_q,    w_late_d;
    logic                           r_kill_q,    w_kill_d;
    logic                           r_hs_prev_q, w_hs_prev_d;
    logic                           r_vs_prev_q, w_vs_prev_d;
    logic                           r_vid_prev_q, w_vid_prev_d;

    logic                           w_hs_rise;
    logic                           w_vs_fall;
    logic                           w_vid_fall;
    logic [c_LINE_W-1:0]            w_row;
    logic                           w_row_ok;
    logic                           w_pix_next;
    logic                           w_cell_wrap;
    logic                           w_step;

    assign w_hs_rise   = h_sync_in & ~r_hs_prev_q;
    assign w_vs_fall   = ~v_sync_in & r_vs_prev_q;
    assign w_vid_fall  = ~video_on_in & r_vid_prev_q;
    assign w_row       = r_line_q >> c_ROW_SHIFT;
    assign w_row_ok    = (w_row < c_ROWS);
    // Once every bit has been shifted out the rest of the line is dark; a
    // late line stays dark regardless of what was loaded.
    assign w_pix_next  = ~r_kill_q & (r_bit_q < c_BITS) & r_buf_q[DATA_WIDTH-1];
    assign w_cell_wrap = (r_cell_q == c_CELL_LAST);

    always_comb begin
        w_state_d    = r_state_q;
        w_line_d     = r_line_q;
        w_buf_d      = r_buf_q;
        w_bit_d      = r_bit_q;
        w_cell_d     = r_cell_q;
        w_addr_d     = r_addr_q;
        w_rd_d       = 1'b0;
        w_pix_d      = 1'b0;
        w_late_d     = r_late_q;
        w_kill_d     = r_kill_q;
        w_step       = 1'b0;
        w_hs_prev_d  = h_sync_in;
        w_vs_prev_d  = v_sync_in;
        w_vid_prev_d = video_on_in;

        if (!v_sync_in) begin
            w_state_d = S_IDLE;
            w_line_d  = '0;
            w_kill_d  = 1'b0;
            // The flag can only be raised mid-fetch, which v_sync excludes, so
            // clearing it on the first low cycle keeps it clear for the pulse.
            if (w_vs_fall) begin
                w_late_d = 1'b0;
            end
        end else begin
            if (w_vid_fall && (r_line_q != c_LINE_SAT)) begin
                w_line_d = r_line_q + 1'b1;
            end

            case (r_state_q)
                S_IDLE, S_BLANK: begin
                    if (w_hs_rise) begin
                        if (w_row_ok) begin
                            w_state_d = S_FETCH;
                            w_rd_d    = 1'b1;
                            w_addr_d  = AUX_ADDRESS_WIDTH'(w_row);
                        end else begin
                            w_state_d = S_BLANK;
                        end
                    end
                end
                S_FETCH, S_WAIT, S_LOAD: begin
                    if (w_vid_fall) begin
                        w_state_d = S_IDLE;
                        w_kill_d  = 1'b0;
                    end else begin
                        // Active video overtook the fetch: flag it and keep
                        // the whole line dark, but let the fetch complete so
                        // the read strobe stays a clean single pulse.
                        if (video_on_in) begin
                            w_late_d = 1'b1;
                            w_kill_d = 1'b1;
                        end
                        if (r_state_q == S_FETCH) begin
                            w_state_d = S_WAIT;
                        end else if (r_state_q == S_WAIT) begin
                            w_state_d = S_LOAD;
                        end else begin
                            w_buf_d   = aux_data_in;
                            w_bit_d   = '0;
                            w_cell_d  = '0;
                            w_state_d = S_READY;
                        end
                    end
                end
                S_READY: begin
                    if (video_on_in) begin
                        w_state_d = S_DRAW;
                        w_step    = 1'b1;
                    end
                end
                S_DRAW: begin
                    if (video_on_in) begin
                        w_step = 1'b1;
                    end else begin
                        w_state_d = S_IDLE;
                        w_kill_d  = 1'b0;
                    end
                end
                default: begin
                    w_state_d = S_IDLE;
                end
            endcase

            // One pixel consumed: emit the current MSB and advance the cell.
            if (w_step) begin
                w_pix_d = w_pix_next;
                if (w_cell_wrap) begin
                    w_cell_d = '0;
                    w_buf_d  = {r_buf_q[DATA_WIDTH-2:0], 1'b0};
                    if (r_bit_q != c_BITS) begin
                        w_bit_d = r_bit_q + 1'b1;
                    end
                end else begin
                    w_cell_d = r_cell_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            r_state_q    <= S_IDLE;
            r_line_q     <= '0;
            r_buf_q      <= '0;
            r_bit_q      <= '0;
            r_cell_q     <= '0;
            r_addr_q     <= '0;
            r_rd_q       <= 1'b0;
            r_pix_q      <= 1'b0;
            r_late_q     <= 1'b0;
            r_kill_q     <= 1'b0;
            r_hs_prev_q  <= 1'b1;
            r_vs_prev_q  <= 1'b1;
            r_vid_prev_q <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_line_q     <= w_line_d;
            r_buf_q      <= w_buf_d;
            r_bit_q      <= w_bit_d;
            r_cell_q     <= w_cell_d;
            r_addr_q     <= w_addr_d;
            r_rd_q       <= w_rd_d;
            r_pix_q      <= w_pix_d;
            r_late_q     <= w_late_d;
            r_kill_q     <= w_kill_d;
            r_hs_prev_q  <= w_hs_prev_d;
            r_vs_prev_q  <= w_vs_prev_d;
            r_vid_prev_q <= w_vid_prev_d;
        end
    end

    assign aux_raddress_out = r_addr_q;
    assign aux_rd_out       = r_rd_q;
    assign pixel_on_out     = r_pix_q;
    assign late_fetch_out   = r_late_q;

endmodule
`default_nettype wire

// File: tb/tb_aux_line_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aux_line_renderer
//  Purpose  : Self-checking bench for aux_line_renderer: table of line
//             vectors plus hand-written reset / v_sync / h_sync corner cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aux_line_renderer;

    localparam int DW = 16;
    localparam int AW = 5;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          vs    = 1'b1;
    logic          hs    = 1'b1;
    logic          vid   = 1'b0;
    logic [DW-1:0] aux_data = '0;
    logic [AW-1:0] addr;
    logic          rd;
    logic          pix;
    logic          late;

    logic [DW-1:0] mem [0:31];

    int            n_checks = 0;
    int            n_errors = 0;
    int            total_fetches = 0;
    logic [AW-1:0] last_addr = '0;
    bit            pix_buf [0:199];
    bit            pix_after;

    typedef struct {
        bit vs;        // v_sync pulse before the lines
        int rep;       // number of identical lines
        int delay;     // cycles from h_sync rising edge to first video pixel
        int nvid;      // active pixels per line
        bit chk_addr;
        int addr;
        int fetch;     // expected aux reads per line
        int lo;        // pixels [lo, hi) expected lit
        int hi;
        int late;      // expected late flag after the line
    } vec_t;

    vec_t tbl [0:7];

    aux_line_renderer #(
        .DATA_WIDTH        (DW),
        .AUX_ADDRESS_WIDTH (AW),
        .AUX_ELEMENTS      (32),
        .CELL_WIDTH        (8),
        .ROW_HEIGHT        (8)
    ) dut (
        .clock_in         (clk),
        .reset_in         (rst_n),
        .v_sync_in        (vs),
        .h_sync_in        (hs),
        .video_on_in      (vid),
        .aux_data_in      (aux_data),
        .aux_raddress_out (addr),
        .aux_rd_out       (rd),
        .pixel_on_out     (pix),
        .late_fetch_out   (late)
    );

    always #5 clk = ~clk;

    // Synchronous-read aux memory: data follows the cycle after the strobe.
    always @(posedge clk) begin
        if (rd) aux_data <= mem[addr];
    end

    always @(negedge clk) begin
        if (rd) begin
            total_fetches <= total_fetches + 1;
            last_addr     <= addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic do_vsync();
        vs = 1'b0;
        repeat (3) tick();
        vs = 1'b1;
        repeat (2) tick();
    endtask

    task automatic run_line(input int delay, input int nvid);
        hs = 1'b0;
        tick();
        tick();
        hs = 1'b1;
        tick();
        repeat (delay - 1) tick();
        for (int p = 0; p < nvid; p++) begin
            vid = 1'b1;
            tick();
            pix_buf[p] = pix;
        end
        vid = 1'b0;
        tick();
        pix_after = pix;
        tick();
        tick();
    endtask

    task automatic check_pixels(input string tag, input int nvid, input int lo, input int hi);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        for (int p = 0; p < nvid; p++) begin
            if (pix_buf[p] != ((p >= lo) && (p < hi))) begin
                bad++;
                if (first < 0) first = p;
            end
        end
        check($sformatf("%s bad pixels (first at %0d)", tag, first), bad, 0);
        check($sformatf("%s pixel after line end", tag), int'(pix_after), 0);
    endtask

    initial begin
        int    f0;
        string tag;

        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[0] = 16'h0001;
        mem[1] = 16'h8000;
        mem[2] = 16'h07FF;

        //          vs    rep  dly nvid chk  adr fch  lo   hi  late
        tbl[0] = '{1'b1,   8,  4, 136, 1'b1, 0,  1, 120, 128, 0}; // lines 0..7
        tbl[1] = '{1'b0,   8,  4, 136, 1'b1, 1,  1,   0,   8, 0}; // lines 8..15
        tbl[2] = '{1'b0,   1,  4, 136, 1'b1, 2,  1,  40, 128, 0}; // line 16
        tbl[3] = '{1'b0,   1,  3, 136, 1'b1, 2,  1,   0,   0, 1}; // video during LOAD
        tbl[4] = '{1'b1,   1,  4, 136, 1'b1, 0,  1, 120, 128, 0}; // new frame clears flag
        tbl[5] = '{1'b0,   1,  1, 136, 1'b1, 0,  1,   0,   0, 1}; // video during FETCH
        tbl[6] = '{1'b1, 256,  1,   8, 1'b0, 0,  1,   0,   0, 1}; // lines 0..255
        tbl[7] = '{1'b0,   2,  4, 136, 1'b0, 0,  0,   0,   0, 1}; // lines 256+, blank

        // ---------------- reset state ----------------
        repeat (3) tick();
        check("reset addr", int'(addr), 0);
        check("reset rd", int'(rd), 0);
        check("reset pixel", int'(pix), 0);
        check("reset late", int'(late), 0);
        rst_n = 1'b1;
        tick();

        // ---------------- table-driven lines ----------------
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].vs) begin
                do_vsync();
                check($sformatf("vec%0d late after vsync", i), int'(late), 0);
            end
            for (int r = 0; r < tbl[i].rep; r++) begin
                f0 = total_fetches;
                run_line(tbl[i].delay, tbl[i].nvid);
                tag = $sformatf("vec%0d line%0d", i, r);
                check({tag, " fetches"}, total_fetches - f0, tbl[i].fetch);
                if (tbl[i].chk_addr) check({tag, " address"}, int'(last_addr), tbl[i].addr);
                check_pixels(tag, tbl[i].nvid, tbl[i].lo, tbl[i].hi);
                check({tag, " late flag"}, int'(late), tbl[i].late);
            end
        end

        // ---------------- reset asserted in WAIT ----------------
        do_vsync();
        for (int r = 0; r < 8; r++) run_line(4, 8);
        f0 = total_fetches;
        hs = 1'b0;
        tick();
        tick();
        hs = 1'b1;
        tick();
        check("fetch strobe high", int'(rd), 1);
        check("fetch address row1", int'(addr), 1);
        tick();
        check("strobe one cycle", int'(rd), 0);
        check("address held in wait", int'(addr), 1);
        rst_n = 1'b0;
        tick();
        check("wait-reset addr", int'(addr), 0);
        check("wait-reset rd", int'(rd), 0);
        check("wait-reset pixel", int'(pix), 0);
        check("wait-reset late", int'(late), 0);
        rst_n = 1'b1;
        tick();
        repeat (6) begin
            vid = 1'b1;
            tick();
            tick();
            vid = 1'b0;
            tick();
        end
        check("no fetch after reset", total_fetches - f0, 1);
        f0 = total_fetches;
        run_line(4, 136);
        check("post-reset fetches", total_fetches - f0, 1);
        check("post-reset address", int'(last_addr), 0);
        check_pixels("post-reset", 136, 120, 128);

        // ---------------- h_sync ignored in READY/DRAW, v_sync mid-DRAW ----------------
        do_vsync();
        for (int r = 0; r < 8; r++) run_line(4, 8);
        f0 = total_fetches;
        hs = 1'b0;
        tick();
        tick();
        hs = 1'b1;
        tick();
        tick();
        tick();
        tick();                      // now READY with row 1 word 0x8000
        hs = 1'b0;
        tick();
        hs = 1'b1;
        tick();                      // h_sync rise while READY
        vid = 1'b1;
        tick();
        check("draw pixel0 lit", int'(pix), 1);
        hs = 1'b0;
        tick();
        hs = 1'b1;
        tick();                      // h_sync rise while DRAW
        check("draw pixel2 lit", int'(pix), 1);
        vs = 1'b0;
        tick();
        check("vsync mid-draw pixel", int'(pix), 0);
        tick();
        check("vsync held pixel", int'(pix), 0);
        vs  = 1'b1;
        vid = 1'b0;
        tick();
        tick();
        check("hsync ignored in ready/draw", total_fetches - f0, 1);
        f0 = total_fetches;
        run_line(4, 136);
        check("after vsync fetches", total_fetches - f0, 1);
        check("after vsync address", int'(last_addr), 0);
        check_pixels("after vsync", 136, 120, 128);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aux_line_renderer.md
AUX_LINE_RENDERER -- requirements
Module: aux_line_renderer

Interface
REQ-001 Parameter DATA_WIDTH, 16, width of one aux word and of the line shift buffer.
REQ-002 Parameter AUX_ADDRESS_WIDTH, 5, aux read address width.
REQ-003 Parameter AUX_ELEMENTS, 32, number of aux words displayed per frame, one word per text row.
REQ-004 Parameter CELL_WIDTH, 8, pixels per displayed bit (power of two).
REQ-005 Parameter ROW_HEIGHT, 8, video lines per displayed word (power of two).
REQ-006 Port clock_in  input  1  pixel clock; one pixel per rising edge; sole clock.
REQ-007 Port reset_in  input  1  synchronous reset, active-low.
REQ-008 Port v_sync_in  input  1  vertical sync, active-low.
REQ-009 Port h_sync_in  input  1  horizontal sync, active-low.
REQ-010 Port video_on_in  input  1  high during active pixels of a line.
REQ-011 Port aux_data_in  input  DATA_WIDTH  aux memory read data, valid the cycle after aux_raddress_out is sampled.
REQ-012 Port aux_raddress_out  output  AUX_ADDRESS_WIDTH  aux memory read address.
REQ-013 Port aux_rd_out  output  1  read strobe, one cycle per fetch.
REQ-014 Port pixel_on_out  output  1  registered pixel value.
REQ-015 Port late_fetch_out  output  1  sticky error: active video began before line word loaded.

Function
REQ-016 FSM states IDLE, FETCH, WAIT, LOAD, READY, DRAW, BLANK; all registers update on clock_in rising edge only.
REQ-017 h_sync rising edge (registered h_sync_in 0 -> 1) in IDLE or BLANK SHALL start a fetch: go to FETCH if row < AUX_ELEMENTS, else BLANK.
REQ-018 Row = line_count / ROW_HEIGHT; line_count counts completed lines since last v_sync, saturating at AUX_ELEMENTS*ROW_HEIGHT.
REQ-019 FETCH: aux_rd_out = 1 for exactly one cycle, aux_raddress_out = row; next WAIT.
REQ-020 WAIT: aux_rd_out = 0, address held; next LOAD.
REQ-021 LOAD: aux_data_in captured into line buffer, bit counter and cell counter cleared; next READY (fetch-to-ready latency 3 cycles from FETCH entry).
REQ-022 READY -> DRAW on first cycle video_on_in = 1.
REQ-023 DRAW: pixel_on_out (registered, 1-cycle latency from video_on_in) = buffer MSB while bit counter < DATA_WIDTH, else 0.
REQ-024 DRAW: cell counter increments every pixel; at CELL_WIDTH-1 it wraps to 0, buffer shifts left one bit (zero fill) and bit counter increments, saturating at DATA_WIDTH.
REQ-025 video_on_in falling edge in DRAW: line_count increments, pixel_on_out = 0, next IDLE.
REQ-026 video_on_in = 1 while in FETCH, WAIT or LOAD: late_fetch_out set, pixel_on_out = 0 for the rest of that line; line still counted on video_on_in falling edge; FSM returns to IDLE at the falling edge (same as DRAW).
REQ-027 BLANK: no aux reads, pixel_on_out = 0; line_count still increments on video_on_in falling edge.
REQ-028 v_sync_in = 0 SHALL override all else: line_count = 0, FSM -> IDLE, aux_rd_out = 0, pixel_on_out = 0, late_fetch_out cleared.
REQ-029 h_sync rising edge while in READY or DRAW SHALL be ignored (no refetch).
REQ-030 video_on_in outside READY/DRAW/FETCH/WAIT/LOAD SHALL yield pixel_on_out = 0.

Reset
REQ-031 reset_in = 0 at a clock edge: FSM IDLE, line_count 0, counters 0, buffer 0, aux_raddress_out 0, aux_rd_out 0, pixel_on_out 0, late_fetch_out 0.
REQ-032 Reset asserted mid-fetch or mid-line SHALL abort it; no further aux_rd_out until the next h_sync rising edge after reset release.
REQ-033 h_sync_in, v_sync_in, video_on_in SHALL have registered previous values reset to 1, 1, 0.

Verification
REQ-034 v_sync pulse, then h_sync rising edge on line 0, aux[0] = 0x0001 -> aux_rd_out one cycle, address 0; pixels 0..119 = 0, pixels 120..127 = 1, pixels 128+ = 0.
REQ-035 Line 16 with aux[2] = 0x07FF -> address 2; pixels 0..39 = 0, 40..127 = 1.
REQ-036 Lines 0..7 -> address 0 each line, exactly 8 fetches; line 8 -> address 1.
REQ-037 video_on_in rises 1 cycle after h_sync rising edge -> late_fetch_out = 1, whole line pixel_on_out = 0; next v_sync low clears flag.
REQ-038 Line 256 (row 32) -> no aux_rd_out, pixel_on_out = 0 until v_sync.
REQ-039 reset_in = 0 in WAIT -> next cycle all outputs 0, FSM IDLE; v_sync_in = 0 mid-DRAW -> pixel_on_out 0 next cycle, line_count 0.
